// File: rtl/axis_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axis_arb_pkg
// Shared types and constants for the packet-level AXI-Stream round-robin
// arbiter (axis_rr_arbiter) and its helpers.
//   arb_state_t        : arbiter FSM state (IDLE / LOCKED)
//   DEFAULT_DATA_WIDTH : default tdata width in bits
//   idx_width()        : width of a port index for a given port count
// -----------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEFAULT_DATA_WIDTH = 64;

  // Port-index width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter_if
// Bundle of the requester-side (s_*) and sink-side (m_*) AXI-Stream signals
// around the arbiter.
//   s_tvalid/s_tdata/s_tkeep/s_tlast : NUM_PORTS requesters, port i packed at
//                                      [i*W +: W]
//   s_tready                         : per-port ready, at most one bit high
//   m_tvalid/m_tdata/m_tkeep/m_tlast : shared registered output
//   m_tready                         : downstream ready
// Modports:
//   master : the environment (requesters + downstream sink)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface axis_rr_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PORTS  = 4
);

  logic [NUM_PORTS-1:0]              s_tvalid;
  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep;
  logic [NUM_PORTS-1:0]              s_tlast;
  logic [NUM_PORTS-1:0]              s_tready;

  logic                              m_tvalid;
  logic [DATA_WIDTH-1:0]             m_tdata;
  logic [DATA_WIDTH/8-1:0]           m_tkeep;
  logic                              m_tlast;
  logic                              m_tready;

  modport master (
    output s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tkeep, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast
  );

endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: returns the first set request bit found
// searching upward from ptr, wrapping modulo NUM_PORTS.
//   req       : request vector
//   ptr       : search start index (must be < NUM_PORTS)
//   gnt_idx   : selected index (0 when nothing is requested)
//   gnt_valid : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [idx_width(NUM_PORTS)-1:0]     ptr,
  output logic [idx_width(NUM_PORTS)-1:0]     gnt_idx,
  output logic                                gnt_valid
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  int pos;

  // Walk the offsets from farthest to nearest so the last hit, which wins,
  // is the one closest to ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_PORTS) begin
        pos = pos - NUM_PORTS;
      end
      if (req[pos[IDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-level round-robin arbiter sharing one AXI-Stream sink between
// NUM_PORTS requesters. A grant is locked from the first accepted beat until
// the tlast beat is accepted; arbitration costs one idle cycle per packet.
// The output is a one-deep register stage with full tready backpressure.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : axis_rr_arbiter_if.slave (s_* requesters, m_* sink)
//   grant_idx  : currently or most recently granted port
//   busy       : high while a packet is locked
//   pkt_cnt    : (only with AXIS_ARB_PKT_CNT_EN) 32-bit completed-packet
//                counter per port, port i at [i*32 +: 32]
// Optional feature macro: AXIS_ARB_PKT_CNT_EN
// -----------------------------------------------------------------------------
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_PORTS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  axis_rr_arbiter_if.slave                bus,
  output logic [idx_width(NUM_PORTS)-1:0] grant_idx,
`ifdef AXIS_ARB_PKT_CNT_EN
  output logic [NUM_PORTS*32-1:0]         pkt_cnt,
`endif
  output logic                            busy
);

  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam int KEEP_W = DATA_WIDTH / 8;

  arb_state_t              state_reg;
  logic [IDX_W-1:0]        grant_reg;
  logic [IDX_W-1:0]        rr_ptr_reg;
  logic [IDX_W-1:0]        rr_ptr_next;
  logic                    m_tvalid_reg;
  logic [DATA_WIDTH-1:0]   m_tdata_reg;
  logic [KEEP_W-1:0]       m_tkeep_reg;
  logic                    m_tlast_reg;

  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic                    locked;
  logic                    out_ready;
  logic                    sel_tvalid;
  logic [DATA_WIDTH-1:0]   sel_tdata;
  logic [KEEP_W-1:0]       sel_tkeep;
  logic                    sel_tlast;
  logic                    accept;
  logic                    pkt_done;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req       (bus.s_tvalid),
    .ptr       (rr_ptr_reg),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  assign locked     = (state_reg == LOCKED);
  // Output stage can take a beat when empty or draining this cycle.
  assign out_ready  = !m_tvalid_reg || bus.m_tready;

  // Only the granted port is ever looked at.
  assign sel_tvalid = bus.s_tvalid[grant_reg];
  assign sel_tdata  = bus.s_tdata[int'(grant_reg)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_tkeep  = bus.s_tkeep[int'(grant_reg)*KEEP_W +: KEEP_W];
  assign sel_tlast  = bus.s_tlast[grant_reg];

  assign accept     = locked && sel_tvalid && out_ready;
  assign pkt_done   = accept && sel_tlast;

  // Wrap explicitly so non-power-of-two port counts work.
  assign rr_ptr_next = (grant_reg == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
      assign bus.s_tready[gi] = locked && (grant_reg == IDX_W'(gi)) && out_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tkeep_reg  <= '0;
      m_tlast_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= pick_idx;
            state_reg <= LOCKED;
          end
        end
        LOCKED: begin
          if (pkt_done) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= rr_ptr_next;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (accept) begin
        m_tvalid_reg <= 1'b1;
        m_tdata_reg  <= sel_tdata;
        m_tkeep_reg  <= sel_tkeep;
        m_tlast_reg  <= sel_tlast;
      end else if (bus.m_tready) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (pkt_done && (grant_reg == IDX_W'(gi))) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
      assign pkt_cnt[gi*32 +: 32] = cnt_reg;
    end
  endgenerate
`endif

  assign bus.m_tvalid = m_tvalid_reg;
  assign bus.m_tdata  = m_tdata_reg;
  assign bus.m_tkeep  = m_tkeep_reg;
  assign bus.m_tlast  = m_tlast_reg;
  assign grant_idx    = grant_reg;
  assign busy         = locked;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed self-checking bench for axis_rr_arbiter (DATA_WIDTH=64,
// NUM_PORTS=4). Covers reset, single-port multi-beat packet, round-robin
// order with wrap, output backpressure, a stalled granted port, mid-packet
// reset and (with AXIS_ARB_PKT_CNT_EN) the per-port packet counters.
// -----------------------------------------------------------------------------
module tb_axis_rr_arbiter;
  import axis_arb_pkg::*;

  localparam int DW = 64;
  localparam int NP = 4;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  logic [1:0] grant_idx;
  logic       busy;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [NP*32-1:0] pkt_cnt;
`endif

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_idx (grant_idx),
`ifdef AXIS_ARB_PKT_CNT_EN
    .pkt_cnt   (pkt_cnt),
`endif
    .busy      (busy)
  );

  // Per-port stimulus, packed onto the interface.
  logic [NP-1:0] sv;
  logic [NP-1:0] sl;
  logic [DW-1:0] td [NP];
  logic [KW-1:0] tk [NP];

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_pack
      assign bus.s_tdata[gi*DW +: DW] = td[gi];
      assign bus.s_tkeep[gi*KW +: KW] = tk[gi];
    end
  endgenerate
  assign bus.s_tvalid = sv;
  assign bus.s_tlast  = sl;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] bdata(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Send one packet on port p with m_tready=1; assumes IDLE and no other
  // requester, so grant takes one edge and each beat one edge after that.
  task automatic send_pkt(input int p, input int n, input logic [7:0] base);
    sv[p] = 1'b1;
    tk[p] = '1;
    td[p] = bdata(base);
    sl[p] = (n == 1);
    step();
    check("pkt_grant", 64'(grant_idx), 64'(p));
    for (int i = 0; i < n; i++) begin
      step();
      check("pkt_data", bus.m_tdata, bdata(8'(base + i)));
      check("pkt_last", 64'(bus.m_tlast), 64'(i == n - 1));
      td[p] = bdata(8'(base + i + 1));
      sl[p] = (i + 1 == n - 1);
      if (i == n - 1) begin
        sv[p] = 1'b0;
        sl[p] = 1'b0;
      end
    end
    $display("packet port=%0d beats=%0d base=0x%0h", p, n, base);
    step();
  endtask

  // Backpressure scenario storage.
  logic [DW-1:0] rx_d [$];
  logic [KW-1:0] rx_k [$];
  logic          rx_l [$];
  logic [7:0]    bp_byte [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
  logic [KW-1:0] bp_keep [4] = '{8'hFF, 8'h0F, 8'h00, 8'hF0};

  int exp_g [12] = '{2, 3, 0, 2, 3, 0, 0, 2, 3, 0, 2, 3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    logic in_fire;
    sv = '0;
    sl = '0;
    for (int i = 0; i < NP; i++) begin
      td[i] = '0;
      tk[i] = '0;
    end
    bus.m_tready = 1'b1;
    rst_n = 1'b0;
    step();
    step();

    // ---------------- reset state ----------------
    check("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check("rst_s_tready", 64'(bus.s_tready), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_tdata", bus.m_tdata, 64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
    check("rst_cnt0", pkt_cnt[31:0], 64'd0);
`endif
    rst_n = 1'b1;

    // ---------------- single port 1, 3-beat packet ----------------
    sv[1] = 1'b1; td[1] = bdata(8'h11); tk[1] = 8'hFF; sl[1] = 1'b0;
    step();
    check("t1_grant", 64'(grant_idx), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_s_tready", 64'(bus.s_tready), 64'h2);
    check("t1_bubble", 64'(bus.m_tvalid), 64'd0);
    step();
    check("t1_v1", 64'(bus.m_tvalid), 64'd1);
    check("t1_d1", bus.m_tdata, bdata(8'h11));
    check("t1_l1", 64'(bus.m_tlast), 64'd0);
    td[1] = bdata(8'h22);
    step();
    check("t1_v2", 64'(bus.m_tvalid), 64'd1);
    check("t1_d2", bus.m_tdata, bdata(8'h22));
    check("t1_l2", 64'(bus.m_tlast), 64'd0);
    td[1] = bdata(8'h33); sl[1] = 1'b1;
    step();
    check("t1_v3", 64'(bus.m_tvalid), 64'd1);
    check("t1_d3", bus.m_tdata, bdata(8'h33));
    check("t1_l3", 64'(bus.m_tlast), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);
    sv[1] = 1'b0; sl[1] = 1'b0;
    step();
    check("t1_drain", 64'(bus.m_tvalid), 64'd0);
    $display("t1 single packet port 1 done");

    // ---------------- round robin 0/2/3 with wrap and reset ----------------
    // rr_ptr is 2 after the port-1 packet, so order starts at 2; after the
    // mid-run reset it restarts from 0.
    for (int p = 0; p < NP; p++) begin
      td[p] = bdata(8'(8'hA0 + p));
      tk[p] = 8'hFF;
    end
    sl = 4'b1101;
    sv = 4'b1101;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        rst_n = 1'b0;
        step();
        check("t2_rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        check("t2_rst_busy", 64'(busy), 64'd0);
        check("t2_rst_grant", 64'(grant_idx), 64'd0);
        check("t2_rst_s_tready", 64'(bus.s_tready), 64'd0);
        rst_n = 1'b1;
      end
      step();
      check("t2_grant", 64'(grant_idx), 64'(exp_g[i]));
      check("t2_bubble", 64'(bus.m_tvalid), 64'd0);
      step();
      check("t2_valid", 64'(bus.m_tvalid), 64'd1);
      check("t2_data", bus.m_tdata, bdata(8'(8'hA0 + exp_g[i])));
      check("t2_last", 64'(bus.m_tlast), 64'd1);
      $display("t2 packet %0d from port %0d", i, grant_idx);
    end
    sv = '0;
    sl = '0;
    step();

    // ---------------- backpressure, 4-beat packet on port 1 ----------------
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      bus.m_tready = !(c >= 3 && c < 8);
      if (sent < 4) begin
        sv[1] = 1'b1;
        td[1] = bdata(bp_byte[sent]);
        tk[1] = bp_keep[sent];
        sl[1] = (sent == 3);
      end else begin
        sv[1] = 1'b0;
        sl[1] = 1'b0;
      end
      #1;
      if (bus.m_tvalid && bus.m_tready) begin
        rx_d.push_back(bus.m_tdata);
        rx_k.push_back(bus.m_tkeep);
        rx_l.push_back(bus.m_tlast);
        $display("t3 beat out data=0x%0h keep=0x%0h last=%0d", bus.m_tdata, bus.m_tkeep, bus.m_tlast);
      end
      if (bus.m_tvalid && !bus.m_tready) begin
        check("t3_stall_s_tready", 64'(bus.s_tready), 64'd0);
      end
      in_fire = sv[1] && bus.s_tready[1];
      step();
      if (in_fire) sent++;
    end
    bus.m_tready = 1'b1;
    check("t3_count", 64'(rx_d.size()), 64'd4);
    for (int i = 0; i < 4 && i < rx_d.size(); i++) begin
      check("t3_data", rx_d[i], bdata(bp_byte[i]));
      check("t3_keep", 64'(rx_k[i]), 64'(bp_keep[i]));
      check("t3_last", 64'(rx_l[i]), 64'(i == 3));
    end

    // ---------------- granted port 1 stalls, port 2 waits ----------------
    sv[1] = 1'b1; td[1] = bdata(8'hD1); tk[1] = 8'hFF; sl[1] = 1'b0;
    step();
    check("t4_grant1", 64'(grant_idx), 64'd1);
    sv[2] = 1'b1; td[2] = bdata(8'hE2); tk[2] = 8'hFF; sl[2] = 1'b1;
    step();
    check("t4_d1", bus.m_tdata, bdata(8'hD1));
    sv[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_grant", 64'(grant_idx), 64'd1);
      check("t4_hold_s_tready", 64'(bus.s_tready), 64'h2);
      check("t4_hold_busy", 64'(busy), 64'd1);
    end
    sv[1] = 1'b1; td[1] = bdata(8'hD2); sl[1] = 1'b1;
    step();
    check("t4_d2", bus.m_tdata, bdata(8'hD2));
    check("t4_l2", 64'(bus.m_tlast), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);
    sv[1] = 1'b0; sl[1] = 1'b0;
    step();
    check("t4_grant2", 64'(grant_idx), 64'd2);
    step();
    check("t4_d_port2", bus.m_tdata, bdata(8'hE2));
    sv[2] = 1'b0; sl[2] = 1'b0;
    step();
    $display("t4 stalled port 1 then port 2 done");

    // ---------------- reset mid-packet, then counters ----------------
    sv[0] = 1'b1; td[0] = bdata(8'hF1); tk[0] = 8'hFF; sl[0] = 1'b0;
    step();
    check("t5_grant0", 64'(grant_idx), 64'd0);
    step();
    check("t5_pre_valid", 64'(bus.m_tvalid), 64'd1);
    rst_n = 1'b0;
    sv[0] = 1'b0;
    step();
    check("t5_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check("t5_m_tdata", bus.m_tdata, 64'd0);
    check("t5_m_tkeep", 64'(bus.m_tkeep), 64'd0);
    check("t5_m_tlast", 64'(bus.m_tlast), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_s_tready", 64'(bus.s_tready), 64'd0);
`ifdef AXIS_ARB_PKT_CNT_EN
    check("t5_cnt_rst0", pkt_cnt[31:0], 64'd0);
    check("t5_cnt_rst2", pkt_cnt[95:64], 64'd0);
`endif
    rst_n = 1'b1;
    step();
    send_pkt(0, 2, 8'h50);
    send_pkt(0, 2, 8'h60);
`ifdef AXIS_ARB_PKT_CNT_EN
    check("t5_cnt0", pkt_cnt[31:0], 64'd2);
    check("t5_cnt1", pkt_cnt[63:32], 64'd0);
`endif
    check("t5_end_grant", 64'(grant_idx), 64'd0);
    check("t5_end_valid", 64'(bus.m_tvalid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
